// File: rtl/test.sv
// Autonomous 2x2 image compressor: loads a generated image into RAM, then emits one averaged pixel every 5 cycles.
// Latency: first compressed pixel after edge IMG_W*IMG_H+5; no backpressure (output is a free-running valid pulse).
module test #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [PIX_W-1:0]      comp_data,
  output logic                  comp_valid,
  output logic [((IMG_W*IMG_H/4) > 1 ? $clog2(IMG_W*IMG_H/4) : 1)-1:0] comp_addr,
  output logic                  done
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NBLK = NPIX / 4;
  localparam int AW   = $clog2(NPIX);
  localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam int CW   = $clog2(IMG_W);
  localparam int HALF_W = IMG_W / 2;
  localparam logic [AW-1:0] LAST_PIX = AW'(NPIX - 1);
  localparam logic [KW-1:0] LAST_BLK = KW'(NBLK - 1);

  typedef enum logic [1:0] {LOAD, ACC, EMIT, DONE} state_t;

  state_t                state, state_nxt;
  logic [AW-1:0]         load_cnt;
  logic [1:0]            sub_cnt;
  logic [KW-1:0]         blk;
  logic [PIX_W+1:0]      sum;
  logic [PIX_W-1:0]      wr_dat;
  logic [PIX_W-1:0]      rd_dat;
  logic [AW-1:0]         rd_addr;
  logic [PIX_W-1:0]      mem [NPIX];

  // Generated test image: pix(r,c) = 16*r + 2*c, truncated to the pixel width.
  always_comb begin
    wr_dat = PIX_W'(32'(load_cnt >> CW) * 16 + 32'(load_cnt & AW'(IMG_W - 1)) * 2);
  end

  // Sub-pixel order within a block: (top,left), (top,right), (bottom,left), (bottom,right).
  always_comb begin
    rd_addr = AW'(((32'(blk) / HALF_W) * 2 + 32'(sub_cnt[1])) * IMG_W
                  + (32'(blk) % HALF_W) * 2 + 32'(sub_cnt[0]));
  end

  always_ff @(posedge clk) begin
    if (state == LOAD)
      mem[load_cnt] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= LOAD;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (load_cnt == LAST_PIX) state_nxt = ACC;
      ACC:     if (sub_cnt == 2'd3)      state_nxt = EMIT;
      EMIT:    state_nxt = (blk == LAST_BLK) ? DONE : ACC;
      DONE:    state_nxt = DONE;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt   <= '0;
      sub_cnt    <= '0;
      blk        <= '0;
      sum        <= '0;
      comp_data  <= '0;
      comp_addr  <= '0;
      comp_valid <= 1'b0;
      done       <= 1'b0;
    end else begin
      comp_valid <= 1'b0;
      done       <= (state == DONE);
      case (state)
        LOAD: load_cnt <= load_cnt + 1'b1;
        ACC: begin
          // First read of a block restarts the sum rather than adding to the previous block.
          sum     <= ((sub_cnt == 2'd0) ? '0 : sum) + {2'b00, rd_dat};
          sub_cnt <= sub_cnt + 1'b1;
        end
        EMIT: begin
          comp_valid <= 1'b1;
          comp_data  <= PIX_W'(sum >> 2);
          comp_addr  <= blk;
          if (blk != LAST_BLK)
            blk <= blk + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test.sv
// Scoreboard bench for the 2x2 compressor: expected pulses are queued by the stimulus and consumed by a monitor.
module tb_test;

  logic       clk;
  logic       rst_n;
  logic [7:0] comp_data;
  logic       comp_valid;
  logic [3:0] comp_addr;
  logic       done;

  typedef struct {
    int data;
    int addr;
    int edge_n;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   edge_cnt;

  test #(.IMG_W(8), .IMG_H(8), .PIX_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .comp_data  (comp_data),
    .comp_valid (comp_valid),
    .comp_addr  (comp_addr),
    .done       (done)
  );

  initial clk = 1'b0;
  always #500 clk = ~clk;

  // Rising edges counted since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per comp_valid pulse and checks hold behaviour between pulses.
  initial begin : monitor
    exp_t e;
    int   pulses;
    int   last_data;
    int   last_addr;
    pulses = 0;
    last_data = 0;
    last_addr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pulses = 0;
      end else if (comp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(comp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("comp_data", 32'(comp_data), e.data);
          check("comp_addr", 32'(comp_addr), e.addr);
          check("pulse_edge", edge_cnt, e.edge_n);
          check("done_early", 32'(done), 32'd0);
          if (pulses > 0)
            check("addr_step", 32'(comp_addr), last_addr + 1);
          pulses++;
          last_data = int'(comp_data);
          last_addr = int'(comp_addr);
        end
      end else if (pulses > 0) begin
        check("hold_data", 32'(comp_data), last_data);
        check("hold_addr", 32'(comp_addr), last_addr);
      end
    end
  end

  // Expected pulses for a full default run: block (i,j) averages to 32*i + 4*j + 9.
  task automatic push_run();
    exp_t e;
    for (int k = 0; k < 16; k++) begin
      e.data   = 32 * (k / 4) + 4 * (k % 4) + 9;
      e.addr   = k;
      e.edge_n = 69 + 5 * k;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_queue_le(input int level, input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() > level && n < budget) begin
      @(negedge clk);
      #10;
      n++;
    end
    if (exp_q.size() > level) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout with %0d pulses outstanding, required <= %0d", name, exp_q.size(), level);
    end
  endtask

  task automatic apply_reset();
    #90 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_comp_data", 32'(comp_data), 32'd0);
    check("rst_comp_addr", 32'(comp_addr), 32'd0);
    check("rst_comp_valid", 32'(comp_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #100 rst_n = 1'b1;
  endtask

  initial begin : stim
    int n;
    rst_n = 1'b0;
    #50;
    check("por_comp_data", 32'(comp_data), 32'd0);
    check("por_comp_addr", 32'(comp_addr), 32'd0);
    check("por_comp_valid", 32'(comp_valid), 32'd0);
    check("por_done", 32'(done), 32'd0);
    #50 rst_n = 1'b1;

    // Run 1: full sequence, then DONE behaviour.
    push_run();
    wait_queue_le(0, 200, "run1_drain");
    check("done_at_last_pulse", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("done_after_last", 32'(done), 32'd1);
    repeat (100) @(negedge clk);
    check("done_sticky", 32'(done), 32'd1);
    check("done_valid_low", 32'(comp_valid), 32'd0);
    check("done_hold_data", 32'(comp_data), 32'd117);
    check("done_hold_addr", 32'(comp_addr), 32'd15);

    // Run 2: abort after block 7, then a complete rerun.
    apply_reset();
    push_run();
    wait_queue_le(8, 200, "run2_block7");
    apply_reset();
    push_run();
    wait_queue_le(0, 200, "run2_drain");

    // Run 3: abort mid-LOAD at edge 30, then a complete rerun.
    apply_reset();
    n = 0;
    while (edge_cnt != 30 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_edge30", edge_cnt, 30);
    apply_reset();
    push_run();
    wait_queue_le(0, 200, "run3_drain");
    @(posedge clk);
    @(negedge clk);
    check("run3_done", 32'(done), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/test.md
TEST -- requirements
Module: test

Interface
REQ-001 The module SHALL have parameter IMG_W, default 8, image width in pixels (even, power of 2).
REQ-002 The module SHALL have parameter IMG_H, default 8, image height in pixels (even, power of 2).
REQ-003 The module SHALL have parameter PIX_W, default 8, pixel bit width.
REQ-004 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-006 Port comp_data, output, PIX_W, compressed (2x2-averaged) pixel value.
REQ-007 Port comp_valid, output, 1, high for exactly one cycle per compressed pixel.
REQ-008 Port comp_addr, output, log2(IMG_W*IMG_H/4), raster index of the compressed pixel.
REQ-009 Port done, output, 1, high once all compressed pixels have been emitted.

Function
REQ-010 The block SHALL run autonomously, with no start input; operation begins at the first rising clk edge with rst_n high.
REQ-011 The block SHALL contain an internal image RAM of IMG_W*IMG_H words of PIX_W bits, addressed as r*IMG_W+c.
REQ-012 FSM states SHALL be LOAD, ACC, EMIT and DONE; the reset state SHALL be LOAD.
REQ-013 In LOAD, the block SHALL write one pixel per cycle at addresses 0..IMG_W*IMG_H-1, with value pix(r,c) = (16*r + 2*c) mod 2^PIX_W.
REQ-014 After the last LOAD write, the FSM SHALL go to ACC for block 0.
REQ-015 Compressed blocks SHALL be processed in raster order: block k = (i,j), with i = k / (IMG_W/2) and j = k mod (IMG_W/2).
REQ-016 In ACC, the block SHALL read the 4 pixels (2i,2j), (2i,2j+1), (2i+1,2j) and (2i+1,2j+1), one per cycle, into a PIX_W+2 bit sum cleared at the start of each block; ACC lasts exactly 4 cycles.
REQ-017 In EMIT (1 cycle), comp_data SHALL be sum>>2 (floor, no rounding), comp_addr SHALL be k, and comp_valid SHALL be 1.
REQ-018 After EMIT, the FSM SHALL go to ACC for block k+1, or to DONE if k was the last block.
REQ-019 Each compressed pixel SHALL take exactly 5 cycles, giving a 4:1 compression ratio.
REQ-020 With the defaults, LOAD SHALL occupy edges 1..64, and comp_valid SHALL be high after edges 69+5k for k = 0..15.
REQ-021 In DONE, done SHALL be 1 and comp_valid 0; the block SHALL stay in DONE until reset.
REQ-022 comp_data and comp_addr SHALL hold their last emitted values whenever comp_valid is 0.
REQ-023 The sum SHALL NOT overflow: PIX_W+2 bits holds 4*(2^PIX_W-1).

Reset
REQ-024 rst_n low SHALL immediately force all of the following: state LOAD, all counters 0, sum 0, comp_data 0, comp_addr 0, comp_valid 0, done 0.
REQ-025 Reset asserted mid-LOAD, mid-ACC or in DONE SHALL abort the run; after release, the full sequence SHALL restart from LOAD with identical timing.
REQ-026 RAM contents need not be cleared by reset, because LOAD rewrites every word.

Verification
REQ-027 Hold rst_n low 100 ns, then release with a 1000 ns clock period -> comp_valid stays 0 for the first 68 edges; after edge 69, comp_data=9 and comp_addr=0.
REQ-028 Full run with defaults -> exactly 16 comp_valid pulses, 5 cycles apart, with comp_data(k) = 32*i + 4*j + 9: k=1 gives 13, k=4 gives 41, k=15 gives 117.
REQ-029 After the last pulse -> done rises on the next edge and stays high; comp_valid stays 0 for at least 100 further cycles.
REQ-030 Assert rst_n low for 2 cycles after block 7 is emitted -> outputs go to 0 asynchronously; after release, the sequence repeats exactly as in REQ-027 and REQ-028.
REQ-031 Assert reset during LOAD (edge 30) -> after release, the first comp_valid occurs 69 edges after release with comp_data=9.
REQ-032 A checker SHALL confirm that comp_addr increments by 1 on each pulse and that done never asserts before pulse 15.
